// File: rtl/rdma_msix_ctrl.sv
// rdma_msix_ctrl: MSI-X table with host PIO access, PBA, and a round-robin EQ interrupt arbiter.
// Optional feature macro RDMA_MSIX_PBA_EN enables the pending bit array and replay on unmask.
`ifndef PIO_DATA_W
`define PIO_DATA_W 256
`endif
`ifndef PIO_HEAD_W
`define PIO_HEAD_W 132
`endif

module rdma_msix_ctrl #(
  parameter int          NUM_VEC_LOG = 6,
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] PBA_OFFSET  = 32'h800
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [`PIO_DATA_W-1:0]         pio_int_req_data,
  input  logic [`PIO_HEAD_W-1:0]         pio_int_req_head,
  input  logic                           pio_int_req_last,
  input  logic                           pio_int_req_valid,
  output logic                           pio_int_req_ready,
  output logic [`PIO_DATA_W-1:0]         pio_int_rrsp_data,
  output logic [`PIO_HEAD_W-1:0]         pio_int_rrsp_head,
  output logic                           pio_int_rrsp_last,
  output logic                           pio_int_rrsp_valid,
  input  logic                           pio_int_rrsp_ready,
  input  logic [NUM_REQ-1:0]             eq_int_req_valid,
  input  logic [NUM_REQ*NUM_VEC_LOG-1:0] eq_int_req_num,
  output logic [NUM_REQ-1:0]             eq_int_req_ready,
  output logic                           int_rsp_valid,
  output logic [127:0]                   int_rsp_data,
  output logic [NUM_VEC_LOG-1:0]         int_rsp_num,
  input  logic                           int_rsp_ready
);
  localparam int          NUM_VEC     = 1 << NUM_VEC_LOG;
  localparam int          PBA_DW      = (NUM_VEC + 31) / 32;
  localparam int          REQ_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          DATA_W      = `PIO_DATA_W;
  localparam logic [31:0] TABLE_BYTES = 32'(16 << NUM_VEC_LOG);

  typedef enum logic [1:0] {UP_REQ = 2'd0, UP_READ = 2'd1, UP_RSP = 2'd2} pio_state_t;
  typedef enum logic [1:0] {IR_IDLE = 2'd0, IR_READ = 2'd1, IR_RSP = 2'd2} ir_state_t;

  logic [31:0]            tbl_r [4][NUM_VEC];
  logic [NUM_VEC-1:0]     mask_r;
  logic [NUM_VEC-1:0]     pending_s;
  logic [PBA_DW*32-1:0]   pba_pad_s;

  pio_state_t             pio_state_r, pio_next_s;
  logic                   req_ready_r, rrsp_valid_r;
  logic [DATA_W-1:0]      rrsp_data_r;
  logic [`PIO_HEAD_W-1:0] rrsp_head_r;
  logic [31:0]            req_addr_s, rd_addr_s, pba_off_s, pba_word_s, rd_word_s;
  logic                   req_wr_s, req_fire_s, tbl_we_s;
  logic [NUM_VEC_LOG-1:0] entry_s;
  logic [1:0]             dw_s;

  ir_state_t              ir_state_r, ir_next_s;
  logic [REQ_W-1:0]       rr_ptr_r, arb_idx_s, next_ptr_s;
  logic                   arb_hit_s, replay_hit_s;
  logic [NUM_VEC_LOG-1:0] replay_vec_s, new_vec_s, vec_r;
  logic [NUM_REQ-1:0]     grant_s;
  logic                   ir_valid_r;
  logic [127:0]           ir_data_r;
  logic [NUM_VEC_LOG-1:0] ir_num_r;

  logic unused_bits_s;
  assign unused_bits_s = ^{pio_int_req_data[DATA_W-1:32], pio_int_req_last, pio_int_req_head[130:128]};

  assign req_addr_s = pio_int_req_head[127:96];
  assign req_wr_s   = pio_int_req_head[131];
  assign req_fire_s = pio_int_req_valid && (pio_state_r == UP_REQ);
  assign entry_s    = req_addr_s[NUM_VEC_LOG+3:4];
  assign dw_s       = req_addr_s[3:2];
  assign tbl_we_s   = req_fire_s && req_wr_s && (req_addr_s < TABLE_BYTES);

  // Table port A write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      tbl_r[dw_s][entry_s] <= pio_int_req_data[31:0];
    end
  end

  // Mask shadow tracks bit 0 of every DW3 write
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= '1;
    end else if (tbl_we_s && (dw_s == 2'd3)) begin
      mask_r[entry_s] <= pio_int_req_data[0];
    end
  end

`ifdef RDMA_MSIX_PBA_EN
  logic [NUM_VEC-1:0] pending_r;
  // Pending is only touched in IR_READ: set when masked, cleared when delivered
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= '0;
    end else if (ir_state_r == IR_READ) begin
      pending_r[vec_r] <= mask_r[vec_r];
    end
  end
  assign pending_s = pending_r;
`else
  assign pending_s = '0;
`endif

  // PBA view padded to whole DWs
  always_comb begin
    pba_pad_s = '0;
    pba_pad_s[NUM_VEC-1:0] = pending_s;
  end

  // PIO read data selection for the latched address
  always_comb begin
    rd_addr_s  = rrsp_head_r[127:96];
    pba_off_s  = rd_addr_s - PBA_OFFSET;
    pba_word_s = {2'b00, pba_off_s[31:2]};
    rd_word_s  = 32'd0;
    if (rd_addr_s < TABLE_BYTES) begin
      rd_word_s = tbl_r[rd_addr_s[3:2]][rd_addr_s[NUM_VEC_LOG+3:4]];
    end else if (rd_addr_s >= PBA_OFFSET) begin
      for (int k = 0; k < PBA_DW; k++) begin
        if (pba_word_s == 32'(k)) rd_word_s = pba_pad_s[32*k +: 32];
        else rd_word_s = rd_word_s;
      end
    end else begin
      rd_word_s = 32'd0;
    end
  end

  // PIO FSM next state
  always_comb begin
    pio_next_s = pio_state_r;
    case (pio_state_r)
      UP_REQ: begin
        if (pio_int_req_valid && !req_wr_s) pio_next_s = UP_READ;
        else pio_next_s = UP_REQ;
      end
      UP_READ: pio_next_s = UP_RSP;
      UP_RSP: begin
        if (pio_int_rrsp_ready) pio_next_s = UP_REQ;
        else pio_next_s = UP_RSP;
      end
      default: pio_next_s = UP_REQ;
    endcase
  end

  // PIO FSM state and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pio_state_r  <= UP_REQ;
      req_ready_r  <= 1'b1;
      rrsp_valid_r <= 1'b0;
      rrsp_data_r  <= '0;
      rrsp_head_r  <= '0;
    end else begin
      pio_state_r  <= pio_next_s;
      req_ready_r  <= (pio_next_s == UP_REQ);
      rrsp_valid_r <= (pio_next_s == UP_RSP);
      if (req_fire_s && !req_wr_s) begin
        rrsp_head_r <= {4'd0, req_addr_s, pio_int_req_head[95:0]};
      end
      if (pio_state_r == UP_READ) begin
        rrsp_data_r <= {{(DATA_W-32){1'b0}}, rd_word_s};
      end
    end
  end

  assign pio_int_req_ready  = req_ready_r;
  assign pio_int_rrsp_valid = rrsp_valid_r;
  assign pio_int_rrsp_last  = rrsp_valid_r;
  assign pio_int_rrsp_data  = rrsp_data_r;
  assign pio_int_rrsp_head  = rrsp_head_r;

  // Lowest unmasked pending vector wins the replay
  always_comb begin
    replay_hit_s = |(pending_s & ~mask_r);
    replay_vec_s = '0;
    for (int v = NUM_VEC - 1; v >= 0; v--) begin
      if (pending_s[v] && !mask_r[v]) replay_vec_s = NUM_VEC_LOG'(v);
      else replay_vec_s = replay_vec_s;
    end
  end

  // Round-robin search starting at the pointer; the lowest offset wins
  always_comb begin
    arb_hit_s = |eq_int_req_valid;
    arb_idx_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eq_int_req_valid[(int'(rr_ptr_r) + i) % NUM_REQ]) arb_idx_s = REQ_W'((int'(rr_ptr_r) + i) % NUM_REQ);
      else arb_idx_s = arb_idx_s;
    end
    new_vec_s  = eq_int_req_num[int'(arb_idx_s)*NUM_VEC_LOG +: NUM_VEC_LOG];
    next_ptr_s = REQ_W'((int'(arb_idx_s) + 1) % NUM_REQ);
  end

  // Grant only in IR_IDLE when no replay is due
  always_comb begin
    grant_s = '0;
    if ((ir_state_r == IR_IDLE) && !replay_hit_s && arb_hit_s) grant_s[arb_idx_s] = 1'b1;
    else grant_s = '0;
  end
  assign eq_int_req_ready = grant_s;

  // Interrupt FSM next state
  always_comb begin
    ir_next_s = ir_state_r;
    case (ir_state_r)
      IR_IDLE: begin
        if (replay_hit_s || arb_hit_s) ir_next_s = IR_READ;
        else ir_next_s = IR_IDLE;
      end
      IR_READ: begin
        if (mask_r[vec_r]) ir_next_s = IR_IDLE;
        else ir_next_s = IR_RSP;
      end
      IR_RSP: begin
        if (int_rsp_ready) ir_next_s = IR_IDLE;
        else ir_next_s = IR_RSP;
      end
      default: ir_next_s = IR_IDLE;
    endcase
  end

  // Interrupt FSM state, pointer, vector latch and descriptor register (port B read)
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_state_r <= IR_IDLE;
      rr_ptr_r   <= '0;
      vec_r      <= '0;
      ir_valid_r <= 1'b0;
      ir_data_r  <= '0;
      ir_num_r   <= '0;
    end else begin
      ir_state_r <= ir_next_s;
      ir_valid_r <= (ir_next_s == IR_RSP);
      if (ir_state_r == IR_IDLE) begin
        if (replay_hit_s) vec_r <= replay_vec_s;
        else if (arb_hit_s) vec_r <= new_vec_s;
      end
      if (|grant_s) rr_ptr_r <= next_ptr_s;
      if ((ir_state_r == IR_READ) && !mask_r[vec_r]) begin
        ir_data_r <= {tbl_r[3][vec_r], tbl_r[2][vec_r], tbl_r[1][vec_r], tbl_r[0][vec_r]};
        ir_num_r  <= vec_r;
      end
    end
  end

  assign int_rsp_valid = ir_valid_r;
  assign int_rsp_data  = ir_data_r;
  assign int_rsp_num   = ir_num_r;

endmodule
